// File: rtl/gobang_board_ctrl_if.sv
// Button pulses into, and board/cursor state out of, the gobang game-state stage.
// The master side presses buttons and watches the board; the slave side is the controller.
interface gobang_board_ctrl_if;
    logic         btn_up;
    logic         btn_down;
    logic         btn_left;
    logic         btn_right;
    logic         btn_place;
    logic         btn_undo;
    logic [224:0] display_black;
    logic [224:0] display_white;
    logic [3:0]   choose_row;
    logic [3:0]   choose_col;
    logic         turn;
    logic [7:0]   move_count;
    logic         place_ok;
    logic         op_err;
    logic         board_full;

    modport master (
        output btn_up, btn_down, btn_left, btn_right, btn_place, btn_undo,
        input  display_black, display_white, choose_row, choose_col,
               turn, move_count, place_ok, op_err, board_full
    );

    modport slave (
        input  btn_up, btn_down, btn_left, btn_right, btn_place, btn_undo,
        output display_black, display_white, choose_row, choose_col,
               turn, move_count, place_ok, op_err, board_full
    );
endinterface

// File: rtl/gobang_board_ctrl.sv
// Gobang game state: cursor, alternating stone placement, full-board detect; one-level undo under GOBANG_UNDO_EN.
// Latency: one button action per cycle, visible on the outputs one edge after it is sampled.
// Backpressure: none; simultaneous pulses resolve place > undo > up > down > left > right, the rest are dropped.
module gobang_board_ctrl #(
    parameter int BOARD_N     = 15,
    parameter int CURSOR_ROW0 = 7,
    parameter int CURSOR_COL0 = 7
) (
    input  logic                clk,
    input  logic                rst,
    gobang_board_ctrl_if.slave  bus
);
    localparam int          CELLS  = BOARD_N * BOARD_N;
    localparam logic [3:0]  EDGE_HI = 4'(BOARD_N - 1);
    localparam logic [0:0]  S_PLAY = 1'b0;
    localparam logic [0:0]  S_FULL = 1'b1;

    logic [CELLS-1:0] black;
    logic [CELLS-1:0] white;
    logic [3:0]       row;
    logic [3:0]       col;
    logic             turn;
    logic [7:0]       move_count;
    logic             place_ok;
    logic             op_err;
    logic [0:0]       state;
    logic [7:0]       cur_idx;
    logic             occupied;

    assign cur_idx  = 8'(row) * 8'(BOARD_N) + 8'(col);
    assign occupied = black[cur_idx] | white[cur_idx];

`ifdef GOBANG_UNDO_EN
    logic [7:0] undo_idx;
    logic       undo_vld;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            undo_idx <= '0;
            undo_vld <= 1'b0;
        end else if (bus.btn_place) begin
            if (state == S_PLAY && !occupied) begin
                undo_idx <= cur_idx;
                undo_vld <= 1'b1;
            end
        end else if (bus.btn_undo) begin
            undo_vld <= 1'b0;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            black      <= '0;
            white      <= '0;
            row        <= 4'(CURSOR_ROW0);
            col        <= 4'(CURSOR_COL0);
            turn       <= 1'b0;
            move_count <= '0;
            place_ok   <= 1'b0;
            op_err     <= 1'b0;
            state      <= S_PLAY;
        end else begin
            place_ok <= 1'b0;
            op_err   <= 1'b0;
            if (bus.btn_place) begin
                // In S_FULL every cell is occupied, but the state check keeps the intent explicit.
                if (state == S_FULL || occupied) begin
                    op_err <= 1'b1;
                end else begin
                    if (turn) white[cur_idx] <= 1'b1;
                    else      black[cur_idx] <= 1'b1;
                    turn       <= ~turn;
                    move_count <= move_count + 8'd1;
                    place_ok   <= 1'b1;
                    if (move_count == 8'(CELLS - 1)) state <= S_FULL;
                end
            end
`ifdef GOBANG_UNDO_EN
            else if (bus.btn_undo) begin
                if (!undo_vld) begin
                    op_err <= 1'b1;
                end else begin
                    black[undo_idx] <= 1'b0;
                    white[undo_idx] <= 1'b0;
                    turn            <= ~turn;
                    move_count      <= move_count - 8'd1;
                    row             <= 4'(undo_idx / 8'(BOARD_N));
                    col             <= 4'(undo_idx % 8'(BOARD_N));
                    state           <= S_PLAY;
                end
            end
`endif
            else if (bus.btn_up) begin
                if (row != 4'd0) row <= row - 4'd1;
            end else if (bus.btn_down) begin
                if (row != EDGE_HI) row <= row + 4'd1;
            end else if (bus.btn_left) begin
                if (col != 4'd0) col <= col - 4'd1;
            end else if (bus.btn_right) begin
                if (col != EDGE_HI) col <= col + 4'd1;
            end
        end
    end

    assign bus.display_black = black;
    assign bus.display_white = white;
    assign bus.choose_row    = row;
    assign bus.choose_col    = col;
    assign bus.turn          = turn;
    assign bus.move_count    = move_count;
    assign bus.place_ok      = place_ok;
    assign bus.op_err        = op_err;
    assign bus.board_full    = (state == S_FULL);
endmodule

// File: tb/tb_gobang_board_ctrl.sv
// Randomized and directed button traffic against a cell-array game model; a monitor compares every cycle.
module tb_gobang_board_ctrl;
`ifdef GOBANG_UNDO_EN
    localparam bit UNDO_EN = 1'b1;
`else
    localparam bit UNDO_EN = 1'b0;
`endif

    typedef struct packed {
        logic [224:0] blk;
        logic [224:0] wht;
        logic [3:0]   row;
        logic [3:0]   col;
        logic         turn;
        logic [7:0]   cnt;
        logic         ok;
        logic         err;
        logic         full;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t exp_q[$];

    gobang_board_ctrl_if bus ();

    gobang_board_ctrl dut (.clk(clk), .rst(rst_n), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: 0 empty, 1 black, 2 white.
    int m_board[15][15];
    int m_r, m_c, m_cnt, u_r, u_c;
    bit m_turn, m_full, u_vld, m_ok, m_err;

    task automatic chk(input string nm, input logic [224:0] act, input logic [224:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) m_board[r][c] = 0;
        m_r = 7; m_c = 7; m_cnt = 0; m_turn = 0; m_full = 0;
        u_vld = 0; u_r = 0; u_c = 0; m_ok = 0; m_err = 0;
    endtask

    // b = {undo, place, right, left, down, up}
    task automatic model_step(input logic [5:0] b);
        m_ok = 0; m_err = 0;
        if (b[4]) begin
            if (m_full || m_board[m_r][m_c] != 0) m_err = 1;
            else begin
                m_board[m_r][m_c] = m_turn ? 2 : 1;
                m_turn = !m_turn;
                m_cnt++;
                m_ok = 1;
                u_vld = 1; u_r = m_r; u_c = m_c;
                if (m_cnt == 225) m_full = 1;
            end
        end else if (b[5] && UNDO_EN) begin
            if (!u_vld) m_err = 1;
            else begin
                m_board[u_r][u_c] = 0;
                m_turn = !m_turn;
                m_cnt--;
                m_r = u_r; m_c = u_c;
                u_vld = 0; m_full = 0;
            end
        end else if (b[0]) m_r = (m_r > 0) ? m_r - 1 : 0;
        else if (b[1]) m_r = (m_r < 14) ? m_r + 1 : 14;
        else if (b[2]) m_c = (m_c > 0) ? m_c - 1 : 0;
        else if (b[3]) m_c = (m_c < 14) ? m_c + 1 : 14;
    endtask

    function automatic exp_t snapshot();
        exp_t e;
        e.blk = '0;
        e.wht = '0;
        for (int r = 0; r < 15; r++)
            for (int c = 0; c < 15; c++) begin
                if (m_board[r][c] == 1) e.blk[r*15+c] = 1'b1;
                if (m_board[r][c] == 2) e.wht[r*15+c] = 1'b1;
            end
        e.row = 4'(m_r); e.col = 4'(m_c); e.turn = m_turn; e.cnt = 8'(m_cnt);
        e.ok = m_ok; e.err = m_err; e.full = m_full;
        return e;
    endfunction

    task automatic drive(input logic [5:0] b);
        bus.btn_up = b[0]; bus.btn_down = b[1]; bus.btn_left = b[2];
        bus.btn_right = b[3]; bus.btn_place = b[4]; bus.btn_undo = b[5];
    endtask

    task automatic do_cycle(input logic [5:0] b);
        @(negedge clk);
        drive(b);
        model_step(b);
        exp_q.push_back(snapshot());
    endtask

    task automatic check_reset_vals(input string nm);
        chk({nm, "_black"}, bus.display_black, '0);
        chk({nm, "_white"}, bus.display_white, '0);
        chk({nm, "_row"}, 225'(bus.choose_row), 225'd7);
        chk({nm, "_col"}, 225'(bus.choose_col), 225'd7);
        chk({nm, "_turn"}, 225'(bus.turn), 225'd0);
        chk({nm, "_count"}, 225'(bus.move_count), 225'd0);
        chk({nm, "_pulses"}, 225'({bus.place_ok, bus.op_err, bus.board_full}), 225'd0);
    endtask

    // Reset lands between edges; outputs must clear before any further clock.
    task automatic do_reset(input string nm);
        @(negedge clk);
        drive(6'd0);
        #2 rst_n = 1'b0;
        #1 check_reset_vals(nm);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic goto_cell(input int r, input int c);
        while (m_r > r) do_cycle(6'b000001);
        while (m_r < r) do_cycle(6'b000010);
        while (m_c > c) do_cycle(6'b000100);
        while (m_c < c) do_cycle(6'b001000);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("black", bus.display_black, e.blk);
                chk("white", bus.display_white, e.wht);
                chk("row", 225'(bus.choose_row), 225'(e.row));
                chk("col", 225'(bus.choose_col), 225'(e.col));
                chk("turn", 225'(bus.turn), 225'(e.turn));
                chk("move_count", 225'(bus.move_count), 225'(e.cnt));
                chk("place_ok", 225'(bus.place_ok), 225'(e.ok));
                chk("op_err", 225'(bus.op_err), 225'(e.err));
                chk("board_full", 225'(bus.board_full), 225'(e.full));
                chk("overlap", bus.display_black & bus.display_white, '0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [5:0] b;
        int wait_cycles;
        drive(6'd0);
        model_reset();
        #12 check_reset_vals("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // First stone at the centre, then a rejected repeat, then idle to see pulses drop.
        do_cycle(6'b010000);
        do_cycle(6'b010000);
        do_cycle(6'b000000);
        // Row saturation at 0, then up+left together moves only the row.
        do_cycle(6'b000010);
        for (int i = 0; i < 10; i++) do_cycle(6'b000001);
        do_cycle(6'b000011);
        do_cycle(6'b000101);
        goto_cell(14, 14);
        do_cycle(6'b000010);
        do_cycle(6'b001000);
        do_cycle(6'b100000);
        do_cycle(6'b000000);

        for (int i = 0; i < 2000; i++) begin
            if (i == 1000) do_reset("mid_reset");
            else begin
                for (int k = 0; k < 6; k++) b[k] = ($urandom_range(0, 3) == 0);
                do_cycle(b);
            end
        end

        // Serpentine fill of the whole board.
        do_reset("pre_fill");
        goto_cell(0, 0);
        for (int r = 0; r < 15; r++) begin
            for (int k = 0; k < 15; k++) begin
                do_cycle(6'b010000);
                if (k < 14) do_cycle((r % 2 == 0) ? 6'b001000 : 6'b000100);
            end
            if (r < 14) do_cycle(6'b000010);
        end
        do_cycle(6'b010000);
        do_cycle(6'b000001);
        do_cycle(6'b010000);
        if (UNDO_EN) begin
            do_cycle(6'b100000);
            do_cycle(6'b010000);
            do_cycle(6'b010000);
        end

        if (UNDO_EN) begin
            do_reset("pre_undo");
            do_cycle(6'b100000);
            goto_cell(0, 0);
            do_cycle(6'b010000);
            goto_cell(3, 3);
            do_cycle(6'b100000);
            do_cycle(6'b100000);
            do_cycle(6'b110000);
            do_cycle(6'b000000);
        end

        do_cycle(6'd0);
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
